reflet_bus_arbiter: RTL

- Shares one Reflet system bus (addr / data_out / write_en / data_in) between two bus masters, e.g. a Reflet CPU core and a DMA engine or second core.
- Arbitrates round-robin and holds the winning request on the bus for a fixed memory latency.
- Returns read data with a one-cycle acknowledge pulse.
- Sits between the masters and the memory/peripheral interconnect.

---
 rtl/reflet_bus_arbiter_if.sv | 20 ++
 rtl/reflet_bus_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/reflet_bus_arbiter_if.sv
// reflet_bus_arbiter_if: request/ack ports of two Reflet bus masters plus the shared bus they are arbitrated onto
//   slave  : arbiter view (takes mN_req/addr/data_out/write_en and data_in, drives acks, read data, bus, grant, busy)
//   master : environment view (masters and memory), the mirror of slave
interface reflet_bus_arbiter_if #(parameter int wordsize = 16);
  logic m0_req, m0_write_en, m0_ack;
  logic [wordsize-1:0] m0_addr, m0_data_out, m0_data_in;
  logic m1_req, m1_write_en, m1_ack;
  logic [wordsize-1:0] m1_addr, m1_data_out, m1_data_in;
  logic [wordsize-1:0] addr, data_out, data_in;
  logic write_en, busy;
  logic [1:0] grant;
  modport slave (
    input m0_req, m0_addr, m0_data_out, m0_write_en, m1_req, m1_addr, m1_data_out, m1_write_en, data_in,
    output m0_ack, m0_data_in, m1_ack, m1_data_in, addr, data_out, write_en, grant, busy
  );
  modport master (
    output m0_req, m0_addr, m0_data_out, m0_write_en, m1_req, m1_addr, m1_data_out, m1_write_en, data_in,
    input m0_ack, m0_data_in, m1_ack, m1_data_in, addr, data_out, write_en, grant, busy
  );
endinterface

// File: rtl/reflet_bus_arbiter.sv
// reflet_bus_arbiter: round-robin sharing of one Reflet bus between two masters with fixed memory latency
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : slave modport of reflet_bus_arbiter_if (master requests/acks, shared bus, grant, busy)
module reflet_bus_arbiter #(
  parameter int wordsize = 16,
  parameter int mem_latency = 2
) (
  input logic clk,
  input logic reset,
  reflet_bus_arbiter_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic [3:0] CNT_LAST = 4'(mem_latency - 1);
  state_t state_q;
  logic [3:0] cnt_q;
  logic own_q, last_q;
  logic [wordsize-1:0] addr_q, data_out_q, m0_data_in_q, m1_data_in_q;
  logic write_en_q, busy_q, m0_ack_q, m1_ack_q;
  logic [1:0] grant_q;
  logic done, c0, c1, win_d;
  // The completing master still holds req on its last edge, so it is kept out of that arbitration.
  always_comb begin
    done = state_q == ACCESS && cnt_q == CNT_LAST;
    c0 = bus.m0_req && !(done && !own_q);
    c1 = bus.m1_req && !(done && own_q);
    win_d = c1 && (!c0 || !last_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      own_q <= 1'b0;
      last_q <= 1'b1;
      addr_q <= '0;
      data_out_q <= '0;
      write_en_q <= 1'b0;
      grant_q <= '0;
      busy_q <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_data_in_q <= '0;
      m1_data_in_q <= '0;
    end else begin
      m0_ack_q <= done && !own_q;
      m1_ack_q <= done && own_q;
      if (done && !own_q) m0_data_in_q <= bus.data_in;
      if (done && own_q) m1_data_in_q <= bus.data_in;
      if (state_q == ACCESS && !done) begin
        cnt_q <= cnt_q + 4'd1;
      end else if (c0 || c1) begin
        state_q <= ACCESS;
        cnt_q <= '0;
        own_q <= win_d;
        last_q <= win_d;
        grant_q <= win_d ? 2'b10 : 2'b01;
        busy_q <= 1'b1;
        addr_q <= win_d ? bus.m1_addr : bus.m0_addr;
        data_out_q <= win_d ? bus.m1_data_out : bus.m0_data_out;
        write_en_q <= win_d ? bus.m1_write_en : bus.m0_write_en;
      end else begin
        state_q <= IDLE;
        grant_q <= '0;
        busy_q <= 1'b0;
        addr_q <= '0;
        data_out_q <= '0;
        write_en_q <= 1'b0;
      end
    end
  end
  assign bus.addr = addr_q;
  assign bus.data_out = data_out_q;
  assign bus.write_en = write_en_q;
  assign bus.grant = grant_q;
  assign bus.busy = busy_q;
  assign bus.m0_ack = m0_ack_q;
  assign bus.m1_ack = m1_ack_q;
  assign bus.m0_data_in = m0_data_in_q;
  assign bus.m1_data_in = m1_data_in_q;
endmodule
